// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared types and constants for the burst reader.
// Return FIFO entry layout and FSM state encoding.
package mem_burst_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/mem_burst_reader_if.sv
// mem_burst_reader_if: command, memory read port and output stream
// of the burst reader.
interface mem_burst_reader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int LEN_W = $clog2(DEPTH) + 1
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic [AW-1:0]    start_addr;
  logic [LEN_W-1:0] start_len;
  logic             busy;
  logic             done;
  logic             mem_read_en;
  logic [AW-1:0]    mem_read_addr;
  logic [WIDTH-1:0] mem_read_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    input  start, start_addr, start_len,
    output busy, done,
    output mem_read_en, mem_read_addr,
    input  mem_read_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output start, start_addr, start_len,
    input  busy, done,
    input  mem_read_en, mem_read_addr,
    output mem_read_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/mem_burst_reader_fifo.sv
// burst_fifo: small synchronous FIFO holding returned read words.
// Storage and pointers are registered; head is read combinationally.
module burst_fifo
  import mem_burst_pkg::*;
#(
  parameter type T = fifo_entry_t,
  parameter int N = FIFO_DEPTH,
  localparam int CW = $clog2(N + 1),
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem_q [N];
  T              mem_d [N];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(N));
  assign count   = cnt_q;
  assign rdata   = mem_q[rp_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = nxt(wp_q);
    end
    if (do_pop) rp_d = nxt(rp_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: reads a wrapping burst from a 1-cycle memory and
// streams it out with last flag and credit-based backpressure.
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 256,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  mem_burst_reader_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  state_e           st_q, st_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             iss_q, iss_d;
  logic             ilast_q, ilast_d;
  logic             vld_q, vld_d;
  logic             vlast_q, vlast_d;

  fifo_entry_t wr_e, rd_e;
  logic        f_full, f_empty, pop;
  logic [1:0]  f_cnt;
  logic [2:0]  occ;
  logic        credit, drained;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Reads issued but not yet in the FIFO count against its space.
  assign pop     = !f_empty && bus.out_ready;
  assign occ     = 3'(iss_q) + 3'(vld_q) + 3'(f_cnt) - 3'(pop);
  assign credit  = occ < 3'(FIFO_DEPTH);
  assign drained = !iss_q && !vld_q && (f_cnt - 2'(pop)) == 2'd0;

  assign wr_e.data = bus.mem_read_data;
  assign wr_e.last = vlast_q;

  burst_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_q),
    .wdata (wr_e),
    .pop   (pop),
    .rdata (rd_e),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    iss_d   = 1'b0;
    ilast_d = 1'b0;
    vld_d   = iss_q;
    vlast_d = iss_q && ilast_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.start_len == '0) begin
            st_d = DONE;
          end else begin
            st_d    = ISSUE;
            iss_d   = 1'b1;
            raddr_d = bus.start_addr;
            addr_d  = next_addr(bus.start_addr);
            rem_d   = bus.start_len - LEN_W'(1);
            ilast_d = (bus.start_len == LEN_W'(1));
          end
        end
      end
      ISSUE: begin
        if (iss_q && ilast_q) begin
          st_d = DRAIN;
        end else if (rem_q != '0 && credit) begin
          iss_d   = 1'b1;
          raddr_d = addr_q;
          addr_d  = next_addr(addr_q);
          rem_d   = rem_q - LEN_W'(1);
          ilast_d = (rem_q == LEN_W'(1));
        end
      end
      DRAIN:   if (drained) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      addr_q  <= '0;
      raddr_q <= '0;
      rem_q   <= '0;
      iss_q   <= 1'b0;
      ilast_q <= 1'b0;
      vld_q   <= 1'b0;
      vlast_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      iss_q   <= iss_d;
      ilast_q <= ilast_d;
      vld_q   <= vld_d;
      vlast_q <= vlast_d;
    end
  end

  assign bus.busy          = (st_q != IDLE);
  assign bus.done          = (st_q == DONE);
  assign bus.mem_read_en   = (st_q == ISSUE) || (st_q == DRAIN);
  assign bus.mem_read_addr = raddr_q;
  assign bus.out_valid     = !f_empty;
  assign bus.out_data      = f_empty ? '0 : WIDTH'(rd_e.data);
  assign bus.out_last      = !f_empty && rd_e.last;

  a_len_legal: assert property (@(posedge clk) disable iff (rst)
    (bus.start && st_q == IDLE) |-> (bus.start_len <= LEN_W'(DEPTH)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    vld_q |-> (!f_full || pop));

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: directed bursts against a queue-based model
// of the expected stream, plus literal latency and data expectations.
module tb_mem_burst_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int LEN_W = 9;
  localparam int AW    = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   done_cnt = 0;

  beat_t            expq [$];
  logic [WIDTH-1:0] got  [$];
  logic             got_l[$];
  int               addr_at[16];
  logic             en_at[16];
  logic             busy_at[16];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  mem_burst_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus();

  mem_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_read_en) rd_q <= mem[bus.mem_read_addr];
  assign bus.mem_read_data = bus.mem_read_en ? rd_q : '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Stream checker: every handshake against the model, hold while stalled.
  initial begin
    logic  stall_prev;
    beat_t hold;
    beat_t e;
    stall_prev = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_beat", {bus.out_data, bus.out_last}, hold);
        end
        if (bus.out_valid && bus.out_ready) begin
          got.push_back(bus.out_data);
          got_l.push_back(bus.out_last);
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_beat: got %0d want none", bus.out_data);
          end else begin
            e = expq.pop_front();
            chk("beat_data", bus.out_data, e.d);
            chk("beat_last", bus.out_last, e.l);
          end
        end
        if (bus.done) done_cnt++;
        stall_prev = bus.out_valid && !bus.out_ready;
        hold = {bus.out_data, bus.out_last};
      end
    end
  end

  task automatic start_burst(input int addr, input int len, output int c0);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = AW'(addr);
    bus.start_len  = LEN_W'(len);
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.start = 1'b0;
    for (int i = 0; i < len; i++)
      expq.push_back({mem[(addr + i) % DEPTH], 1'(i == len - 1)});
  endtask

  task automatic run_burst(input int c0, input int budget,
                           output int fv, output int dr);
    int rel;
    fv = -1;
    dr = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      rel = cyc - c0 + 1;
      if (rel >= 0 && rel < 16) begin
        addr_at[rel] = bus.mem_read_addr;
        en_at[rel]   = bus.mem_read_en;
        busy_at[rel] = bus.busy;
      end
      if (bus.out_valid && fv < 0) fv = rel;
      if (bus.done) begin
        dr = rel;
        break;
      end
    end
    if (dr < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got none want done pulse");
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_done_after"}, bus.done, 0);
    chk({tag, "_model_empty"}, expq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_en"}, bus.mem_read_en, 0);
    chk({tag, "_addr"}, bus.mem_read_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
  endtask

  initial begin
    int c0, fv, dr, dc;
    for (int a = 0; a < DEPTH; a++) mem[a] = WIDTH'(a * 3);
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.start_len  = '0;

    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst: 10..13 -> 30,33,36,39
    got.delete(); got_l.delete();
    dc = done_cnt;
    start_burst(10, 4, c0);
    run_burst(c0, 50, fv, dr);
    chk("basic_en_c1", en_at[1], 1);
    chk("basic_addr_c1", addr_at[1], 10);
    chk("basic_first_valid", fv, 3);
    chk("basic_done_cycle", dr, 7);
    chk("basic_nbeats", got.size(), 4);
    chk("basic_b0", got[0], 30);
    chk("basic_b1", got[1], 33);
    chk("basic_b2", got[2], 36);
    chk("basic_b3", got[3], 39);
    chk("basic_last_b0", got_l[0], 0);
    chk("basic_last_b3", got_l[3], 1);
    after_done("basic");
    chk("basic_done_pulses", done_cnt - dc, 1);

    // Backpressure: random ready, 16 beats from address 0
    got.delete(); got_l.delete();
    dc = done_cnt;
    rmode = 1;
    start_burst(0, 16, c0);
    run_burst(c0, 400, fv, dr);
    rmode = 0;
    after_done("bp");
    chk("bp_nbeats", got.size(), 16);
    chk("bp_b15", got[15], 45);
    chk("bp_done_pulses", done_cnt - dc, 1);

    // Wrap-around at the top of memory
    got.delete(); got_l.delete();
    start_burst(254, 4, c0);
    run_burst(c0, 50, fv, dr);
    chk("wrap_addr_c1", addr_at[1], 254);
    chk("wrap_addr_c2", addr_at[2], 255);
    chk("wrap_addr_c3", addr_at[3], 0);
    chk("wrap_addr_c4", addr_at[4], 1);
    chk("wrap_b1", got[1], 765);
    chk("wrap_b2", got[2], 0);
    chk("wrap_b3", got[3], 3);
    chk("wrap_done_cycle", dr, 7);
    after_done("wrap");

    // Zero length: one busy/done cycle, nothing else
    got.delete(); got_l.delete();
    start_burst(40, 0, c0);
    run_burst(c0, 10, fv, dr);
    chk("zero_done_cycle", dr, 1);
    chk("zero_busy_c1", busy_at[1], 1);
    chk("zero_en_c1", en_at[1], 0);
    chk("zero_no_valid", fv, -1);
    after_done("zero");
    chk("zero_nbeats", got.size(), 0);

    // Start while busy is ignored
    got.delete(); got_l.delete();
    dc = done_cnt;
    start_burst(20, 8, c0);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = AW'(100);
    bus.start_len  = LEN_W'(5);
    @(posedge clk);
    #1 bus.start = 1'b0;
    run_burst(c0, 60, fv, dr);
    chk("busy_done_cycle", dr, 11);
    after_done("busy");
    chk("busy_nbeats", got.size(), 8);
    chk("busy_b0", got[0], 60);
    chk("busy_b7", got[7], 81);
    repeat (3) @(negedge clk);
    chk("busy_done_pulses", done_cnt - dc, 1);

    // Reset after two beats, then a fresh burst
    got.delete(); got_l.delete();
    dc = done_cnt;
    start_burst(0, 8, c0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (got.size() >= 2) break;
    end
    chk("rst_beats_before", got.size(), 2);
    #1 rst = 1'b1;
    #1;
    chk_zero("midrst");
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_no_done", done_cnt - dc, 0);
    got.delete(); got_l.delete();
    start_burst(5, 2, c0);
    run_burst(c0, 50, fv, dr);
    chk("rst_done_cycle", dr, 5);
    chk("rst_b0", got[0], 15);
    chk("rst_b1", got[1], 18);
    chk("rst_last_b1", got_l[1], 1);
    after_done("rst");
    chk("rst_done_pulses", done_cnt - dc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
